addsub_share_arbiter: RTL and testbench
=======================================

Name: addsub_share_arbiter

Overview:
- Shares one `adder_subtractor_8bit` instance between NUM_REQ requesters using round-robin arbitration.
- Requesters issue operations with a valid/ready handshake: A, B, and Op (0 = add, 1 = subtract).
- The block registers the result and returns it on a single response channel, tagged with the requester ID, with valid/ready backpressure.
- It sits between requester blocks and the shared 8-bit adder/subtractor datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i: requester i has an operation pending.
- req_ready  output  NUM_REQ  one-hot or zero; bit i: requester i is granted this cycle (combinational).
- req_a  input  8*NUM_REQ  operand A; requester i uses bits [8i+7:8i].
- req_b  input  8*NUM_REQ  operand B; same packing as req_a.
- req_op  input  NUM_REQ  bit i: 0 = A+B, 1 = A-B.
- rsp_valid  output  1  registered result is valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_sum  output  8  registered Sum.
- rsp_cout  output  1  registered Cout.
- op_count  output  16  number of accepted operations, saturating.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
  - In any cycle with rst=1: req_ready=0.
  - After the reset edge: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, op_count=0, rr_ptr=0.
  - Reset mid-operation discards any held response; no grant is issued during a reset cycle.
- Arithmetic (from the shared datapath):
  - Op=0: {Cout,Sum} = A+B.
  - Op=1: {Cout,Sum} = A + ~B + 1. Cout=1 means no borrow (A>=B unsigned); Cout=0 means borrow.
  - Result is 8-bit and wraps modulo 256. No signed-overflow flag.
- Grant rules:
  - can_issue = !rsp_valid || rsp_ready.
  - If can_issue and any req_valid is set, grant the first valid requester found scanning upward from rr_ptr, wrapping at NUM_REQ-1 to 0.
  - req_ready has exactly one bit set, for the granted requester; otherwise req_ready=0.
  - req_ready never depends on that requester's own req_valid except through the selection itself: no ready without valid.
- Datapath mux: the granted requester's A/B/Op drive the shared adder/subtractor. When nothing is granted, operands are driven to 0, Op=0.
- Transfer (req_valid[i] && req_ready[i]) at edge k:
  - rsp_sum, rsp_cout, and rsp_id=i load at edge k.
  - rsp_valid=1 after edge k. Latency is 1 cycle.
  - rr_ptr ← (i+1) mod NUM_REQ.
  - op_count increments, saturating at 0xFFFF.
- Response channel:
  - If rsp_valid && rsp_ready with no new transfer: rsp_valid ← 0.
  - If rsp_valid && rsp_ready with a simultaneous transfer: the new result replaces the old one and rsp_valid stays 1. Sustained throughput is one op per cycle.
  - If rsp_valid && !rsp_ready: all rsp_* outputs hold stable, req_ready=0, rr_ptr holds.
- State machine: 2 states, derived from rsp_valid.
  - EMPTY → FULL on a transfer.
  - FULL → FULL on (rsp_ready && transfer) or on !rsp_ready.
  - FULL → EMPTY on (rsp_ready && !transfer).
- Fairness:
  - A requester holding req_valid high is granted within NUM_REQ grants.
  - req_valid and operands must stay stable until granted. Dropping req_valid early is legal; the request is simply not taken.
- Boundary cases:
  - A single active requester is granted every available cycle.
  - NUM_REQ not a power of two: rr_ptr wraps at NUM_REQ-1, never at 2^ID_W-1.

Test Plan:
- Reset check: after reset, rsp_valid=0 and op_count=0. Req0 issues A=0x0F, B=0x01, Op=0 → req_ready=0001; next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x10, rsp_cout=0.
- Arithmetic set through req2 with rsp_ready=1:
  - 0x0F−0x01 → 0x0E, cout 1.
  - 0xF0+0x0F → 0xFF, cout 0.
  - 0xF0−0x0F → 0xE1, cout 1.
  - 0xFF+0x01 → 0x00, cout 1.
  - 0x01−0x02 → 0xFF, cout 0.
- Round-robin: all four req_valid held high, rsp_ready=1 → grant order 0,1,2,3,0,…. rsp_id follows that order one cycle later, and op_count increments every cycle.
- Backpressure: response held with rsp_ready=0 for 3 cycles → rsp_* outputs stable and req_ready=0. When rsp_ready rises, a new grant and the new response appear back-to-back with no bubble.
- Reset mid-stream: assert rst while rsp_valid=1 and requests are pending → next cycle rsp_valid=0, op_count=0, and the grant restarts from requester 0.
- Saturation: preload by running 65535 ops, then 2 more → op_count=0xFFFF.

Source files
------------

// File: rtl/addsub_share_arbiter.sv
// Round-robin arbiter sharing one 8-bit adder/subtractor between NUM_REQ requesters.
// The result is registered and returned with the owning requester's ID.

module adder_subtractor_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       op_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);
    logic [7:0] b_eff;
    logic [8:0] res;

    // Subtraction is A + ~B + 1, so Cout=1 means no borrow.
    assign b_eff  = op_i ? ~b_i : b_i;
    assign res    = {1'b0, a_i} + {1'b0, b_eff} + {8'd0, op_i};
    assign sum_o  = res[7:0];
    assign cout_o = res[8];
endmodule

module addsub_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_sum,
    output logic                 rsp_cout,
    output logic [15:0]          op_count
);
    // Handshake: a transfer happens on req_valid[i] && req_ready[i] at a rising
    // edge; a response is consumed on rsp_valid && rsp_ready at a rising edge.

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] rsp_id_q;
    logic [7:0]      rsp_sum_q;
    logic            rsp_cout_q;
    logic [15:0]     op_count_q, op_count_d;

    logic            can_issue;
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;
    logic [7:0]      alu_a, alu_b;
    logic            alu_op;
    logic [7:0]      alu_sum;
    logic            alu_cout;

    assign rsp_valid = (state_q == FULL);
    assign can_issue = !rsp_valid || rsp_ready;

    // Scan upward from rr_ptr, wrapping at NUM_REQ-1 (not at 2^ID_W-1).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        req_ready   = '0;
        if (!rst && can_issue) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (int'(rr_ptr_q) + k >= NUM_REQ) begin
                    cand = ID_W'(int'(rr_ptr_q) + k - NUM_REQ);
                end else begin
                    cand = ID_W'(int'(rr_ptr_q) + k);
                end
                if (!grant_found && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Idle datapath sees zero operands and add.
    always_comb begin
        alu_a  = 8'd0;
        alu_b  = 8'd0;
        alu_op = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_found && grant_idx == ID_W'(i)) begin
                alu_a  = req_a[8*i +: 8];
                alu_b  = req_b[8*i +: 8];
                alu_op = req_op[i];
            end
        end
    end

    adder_subtractor_8bit u_alu (
        .a_i    (alu_a),
        .b_i    (alu_b),
        .op_i   (alu_op),
        .sum_o  (alu_sum),
        .cout_o (alu_cout)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        op_count_d = op_count_q;
        case (state_q)
            EMPTY: if (grant_found) state_d = FULL;
            FULL:  if (rsp_ready && !grant_found) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (grant_found) begin
            if (int'(grant_idx) == NUM_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + ID_W'(1);
            end
            if (op_count_q != 16'hFFFF) begin
                op_count_d = op_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= '0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= 8'd0;
            rsp_cout_q <= 1'b0;
            op_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            op_count_q <= op_count_d;
            if (grant_found) begin
                rsp_id_q   <= grant_idx;
                rsp_sum_q  <= alu_sum;
                rsp_cout_q <= alu_cout;
            end
        end
    end

    assign rsp_id   = rsp_id_q;
    assign rsp_sum  = rsp_sum_q;
    assign rsp_cout = rsp_cout_q;
    assign op_count = op_count_q;
endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Bench for addsub_share_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration and arithmetic.

module tb_addsub_share_arbiter;
  localparam int N = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_a = '0;
  logic [8*N-1:0] req_b = '0;
  logic [N-1:0]   req_op = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IDW-1:0] rsp_id;
  logic [7:0]     rsp_sum;
  logic           rsp_cout;
  logic [15:0]    op_count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_ptr, m_count, m_valid, m_id, m_sum, m_cout;

  addsub_share_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ptr = 0; m_count = 0; m_valid = 0; m_id = 0; m_sum = 0; m_cout = 0;
  endtask

  function automatic int exp_grant();
    if (m_valid != 0 && !rsp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_edge(int g);
    int a, b;
    if (g >= 0) begin
      a = int'(req_a[8*g +: 8]);
      b = int'(req_b[8*g +: 8]);
      if (req_op[g]) begin
        m_sum  = (a - b + 256) % 256;
        m_cout = (a >= b) ? 1 : 0;
      end else begin
        m_sum  = (a + b) % 256;
        m_cout = (a + b > 255) ? 1 : 0;
      end
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % N;
      if (m_count < 65535) m_count = m_count + 1;
    end else if (m_valid != 0 && rsp_ready) begin
      m_valid = 0;
    end
  endtask

  // Samples req_ready before the edge, advances the model across the edge.
  task automatic cycle(output logic [N-1:0] obs_ready, output int g);
    #1;
    obs_ready = req_ready;
    g = exp_grant();
    @(posedge clk);
    model_edge(g);
    #1;
  endtask

  task automatic set_req(int i, logic [7:0] a, logic [7:0] b, logic op);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_op[i]       = op;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [N-1:0] obs;
    int g;
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== '0) begin
      n_fail++; $display("FAIL reset_ready got=%b want=0", req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '0;
    model_reset();
    n_tests++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, op_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b id=%0d sum=%h c=%b cnt=%0d want all 0",
               rsp_valid, rsp_id, rsp_sum, rsp_cout, op_count);
    end
    set_req(0, 8'h0F, 8'h01, 1'b0);
    req_valid = 4'b0001;
    cycle(obs, g);
    n_tests++;
    if (obs !== 4'b0001) begin
      n_fail++; $display("FAIL first_grant got=%b want=0001", obs);
    end
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'h10 || rsp_cout !== 1'b0) begin
      n_fail++;
      $display("FAIL first_rsp got v=%b id=%0d sum=%h c=%b want v=1 id=0 sum=10 c=0",
               rsp_valid, rsp_id, rsp_sum, rsp_cout);
    end
  endtask

  task automatic test_arith();
    logic [7:0] va [5] = '{8'h0F, 8'hF0, 8'hF0, 8'hFF, 8'h01};
    logic [7:0] vb [5] = '{8'h01, 8'h0F, 8'h0F, 8'h01, 8'h02};
    logic       vo [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] es [5] = '{8'h0E, 8'hFF, 8'hE1, 8'h00, 8'hFF};
    logic       ec [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [N-1:0] obs;
    int g;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      set_req(2, va[i], vb[i], vo[i]);
      cycle(obs, g);
      n_tests++;
      if (obs !== 4'b0100) begin
        n_fail++; $display("FAIL arith_ready[%0d] got=%b want=0100", i, obs);
      end
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== es[i] || rsp_cout !== ec[i]) begin
        n_fail++;
        $display("FAIL arith[%0d] got v=%b id=%0d sum=%h c=%b want v=1 id=2 sum=%h c=%b",
                 i, rsp_valid, rsp_id, rsp_sum, rsp_cout, es[i], ec[i]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] obs;
    int g;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
    req_valid = '1;
    for (int k = 0; k < 10; k++) begin
      cycle(obs, g);
      n_tests++;
      if (obs !== onehot(k % N)) begin
        n_fail++; $display("FAIL rr_grant[%0d] got=%b want=%b", k, obs, onehot(k % N));
      end
      n_tests++;
      if (rsp_valid !== 1'b1 || int'(rsp_id) != k % N || int'(op_count) != k + 1
          || int'(rsp_sum) != m_sum || int'(rsp_cout) != m_cout) begin
        n_fail++;
        $display("FAIL rr_rsp[%0d] got v=%b id=%0d cnt=%0d sum=%h want id=%0d cnt=%0d sum=%h",
                 k, rsp_valid, rsp_id, op_count, rsp_sum, k % N, k + 1, m_sum);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] obs;
    logic [11:0]  snap;
    int g;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
    req_valid = '1;
    cycle(obs, g);
    snap = {rsp_valid, rsp_id, rsp_sum, rsp_cout};
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(obs, g);
      n_tests++;
      if (obs !== '0) begin
        n_fail++; $display("FAIL bp_ready[%0d] got=%b want=0", k, obs);
      end
      n_tests++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== snap || rsp_id !== 2'd0
          || op_count !== 16'd1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got=%h want=%h cnt=%0d", k,
                 {rsp_valid, rsp_id, rsp_sum, rsp_cout}, snap, op_count);
      end
    end
    rsp_ready = 1'b1;
    cycle(obs, g);
    n_tests++;
    if (obs !== 4'b0010 || rsp_valid !== 1'b1 || rsp_id !== 2'd1
        || int'(rsp_sum) != m_sum || int'(rsp_cout) != m_cout) begin
      n_fail++;
      $display("FAIL bp_release got ready=%b v=%b id=%0d sum=%h want ready=0010 v=1 id=1 sum=%h",
               obs, rsp_valid, rsp_id, rsp_sum, m_sum);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] obs;
    int g;
    int errs;
    errs = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle(obs, g);
      if (g >= 0) req_valid[g] = 1'b0;
      n_tests++;
      if (obs !== onehot(g)) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_ready[%0d] got=%b want=%b", c, obs, onehot(g));
      end
      n_tests++;
      if (int'(rsp_valid) != m_valid || int'(op_count) != m_count
          || (m_valid != 0 && (int'(rsp_id) != m_id || int'(rsp_sum) != m_sum
                               || int'(rsp_cout) != m_cout))) begin
        n_fail++; errs++;
        if (errs < 10)
          $display("FAIL rand_rsp[%0d] got v=%b id=%0d sum=%h c=%b cnt=%0d want v=%0d id=%0d sum=%h c=%0d cnt=%0d",
                   c, rsp_valid, rsp_id, rsp_sum, rsp_cout, op_count,
                   m_valid, m_id, m_sum, m_cout, m_count);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] obs;
    int g;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
    req_valid = '1;
    cycle(obs, g);
    cycle(obs, g);
    rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== '0 || rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_ready got=%b v=%b want ready=0 v=1", req_ready, rsp_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    n_tests++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd0) begin
      n_fail++; $display("FAIL midrst_state got v=%b cnt=%0d want v=0 cnt=0", rsp_valid, op_count);
    end
    cycle(obs, g);
    n_tests++;
    if (obs !== 4'b0001 || rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_restart got ready=%b id=%0d want ready=0001 id=0", obs, rsp_id);
    end
    req_valid = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 8'h01, 8'h01, 1'b0);
    req_valid = 4'b0001;
    repeat (65534) @(posedge clk);
    #1;
    n_tests++;
    if (op_count !== 16'hFFFE) begin
      n_fail++; $display("FAIL sat_pre got=%h want=fffe", op_count);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (op_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_reach got=%h want=ffff", op_count);
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (op_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold got=%h want=ffff", op_count);
    end
    req_valid = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_arith();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
